// File: rtl/bus_cycle_controller.sv
//------------------------------------------------------------------------------
// Module   : bus_cycle_controller
// Brief    : 8088 peripheral bus-cycle sequencer with window decode, wait states and RAM strobes
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bus_cycle_controller #(
    parameter bit          IS_IO       = 1'b0,
    parameter logic [19:0] BASE_ADDR   = 20'h00000,
    parameter logic [19:0] ADDR_MASK   = 20'hF0000,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned MEM_AW      = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ALE,
    input  logic              IOM,
    input  logic              RD,
    input  logic              WR,
    input  logic [7:0]        AD,
    input  logic [11:0]       A,
    output logic [7:0]        data_out,
    output logic              data_oe,
    output logic              READY,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              selected
);

    localparam logic [3:0] c_wait_states = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_ARMED  = 3'd2,
        S_RWAIT  = 3'd3,
        S_RCAP   = 3'd4,
        S_WWAIT  = 3'd5,
        S_ENDC   = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [19:0] r_addr;
    logic        r_iom;
    logic        r_ale_d;
    logic [3:0]  r_cnt;
    logic        r_selected;
    logic        r_oe;
    logic [7:0]  r_data_out;
    logic [7:0]  r_wdata;
    logic        r_we;

    logic [3:0]  w_cnt_next;
    logic        w_sel_next;
    logic        w_oe_next;
    logic [7:0]  w_dout_next;
    logic [7:0]  w_wdata_next;
    logic        w_we_next;
    logic        w_ready;
    logic        w_re;
    logic        w_hit;
    logic        w_at_ws;

    assign w_hit   = (((r_addr ^ BASE_ADDR) & ADDR_MASK) == 20'd0) && (r_iom == ~IS_IO);
    assign w_at_ws = (r_cnt == c_wait_states);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_addr     <= 20'd0;
            r_iom      <= 1'b0;
            r_ale_d    <= 1'b0;
            r_cnt      <= 4'd0;
            r_selected <= 1'b0;
            r_oe       <= 1'b0;
            r_data_out <= 8'd0;
            r_wdata    <= 8'd0;
            r_we       <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_ale_d    <= ALE;
            if (ALE) begin
                r_addr <= {A, AD};
                r_iom  <= IOM;
            end
            r_cnt      <= w_cnt_next;
            r_selected <= w_sel_next;
            r_oe       <= w_oe_next;
            r_data_out <= w_dout_next;
            r_wdata    <= w_wdata_next;
            r_we       <= w_we_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_cnt_next   = r_cnt;
        w_sel_next   = r_selected;
        w_oe_next    = r_oe;
        w_dout_next  = r_data_out;
        w_wdata_next = r_wdata;
        w_we_next    = 1'b0;
        w_ready      = 1'b1;
        w_re         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!ALE && r_ale_d) w_next = S_DECODE;
            end
            S_DECODE: begin
                if (ALE || !w_hit) begin
                    w_next = S_IDLE;
                end else begin
                    w_sel_next = 1'b1;
                    w_next     = S_ARMED;
                end
            end
            S_ARMED: begin
                if (ALE) begin
                    w_sel_next = 1'b0;
                    w_next     = S_IDLE;
                end else if (!RD && !WR) begin
                    w_next = S_ENDC;
                end else if (!RD) begin
                    w_cnt_next = 4'd0;
                    w_next     = S_RWAIT;
                end else if (!WR) begin
                    w_cnt_next = 4'd0;
                    w_next     = S_WWAIT;
                end
            end
            // READY stays low through the mem_re cycle to cover RAM latency
            S_RWAIT: begin
                w_ready = 1'b0;
                if (RD) begin
                    w_sel_next = 1'b0;
                    w_oe_next  = 1'b0;
                    w_next     = S_IDLE;
                end else if (w_at_ws) begin
                    w_re   = 1'b1;
                    w_next = S_RCAP;
                end else if (r_cnt != 4'hF) begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            S_RCAP: begin
                if (RD) begin
                    w_sel_next = 1'b0;
                    w_next     = S_IDLE;
                end else begin
                    w_dout_next = mem_rdata;
                    w_oe_next   = 1'b1;
                    w_next      = S_ENDC;
                end
            end
            S_WWAIT: begin
                if (WR) begin
                    w_sel_next = 1'b0;
                    w_next     = S_IDLE;
                end else if (w_at_ws) begin
                    w_wdata_next = AD;
                    w_we_next    = 1'b1;
                    w_next       = S_ENDC;
                end else begin
                    w_ready = 1'b0;
                    if (r_cnt != 4'hF) w_cnt_next = r_cnt + 4'd1;
                end
            end
            S_ENDC: begin
                if (RD && WR) begin
                    w_oe_next  = 1'b0;
                    w_sel_next = 1'b0;
                    w_next     = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Gating by RD keeps the data bus released the moment the host ends the read
    assign data_oe   = r_oe & ~RD & r_selected;
    assign data_out  = r_data_out;
    assign READY     = w_ready;
    assign mem_addr  = r_addr[MEM_AW-1:0];
    assign mem_wdata = r_wdata;
    assign mem_we    = r_we;
    assign mem_re    = w_re;
    assign selected  = r_selected;

endmodule

`default_nettype wire

// File: tb/tb_bus_cycle_controller.sv
//------------------------------------------------------------------------------
// Module   : tb_bus_cycle_controller
// Brief    : directed bench; four instances (mem WS0/WS2/WS3, IO WS0) share one bus
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bus_cycle_controller;

    logic        CLK;
    logic        RESET;
    logic        ALE;
    logic        IOM;
    logic        RD;
    logic        WR;
    logic [7:0]  AD;
    logic [11:0] A;

    logic [3:0]  rdy;
    logic [3:0]  oe;
    logic [3:0]  we;
    logic [3:0]  re;
    logic [3:0]  sel;
    logic [7:0]  dout  [4];
    logic [15:0] maddr [4];
    logic [7:0]  wdata [4];
    logic [7:0]  rdata [4];
    logic [7:0]  ram   [4][256];

    int n_checks = 0;
    int n_fail   = 0;
    int n_we  [4] = '{default: 0};
    int n_re  [4] = '{default: 0};
    int n_rdy [4] = '{default: 0};
    int n_oe  [4] = '{default: 0};
    int n_sel [4] = '{default: 0};
    int b_we  [4];
    int b_re  [4];
    int b_rdy [4];
    int b_oe  [4];
    int b_sel [4];

    bus_cycle_controller #(.IS_IO(1'b0), .BASE_ADDR(20'h00000), .ADDR_MASK(20'hF0000), .WAIT_STATES(0), .MEM_AW(16)) u_ws0 (
        .CLK(CLK), .RESET(RESET), .ALE(ALE), .IOM(IOM), .RD(RD), .WR(WR), .AD(AD), .A(A),
        .data_out(dout[0]), .data_oe(oe[0]), .READY(rdy[0]), .mem_addr(maddr[0]), .mem_wdata(wdata[0]),
        .mem_we(we[0]), .mem_re(re[0]), .mem_rdata(rdata[0]), .selected(sel[0]));

    bus_cycle_controller #(.IS_IO(1'b0), .BASE_ADDR(20'h00000), .ADDR_MASK(20'hF0000), .WAIT_STATES(2), .MEM_AW(16)) u_ws2 (
        .CLK(CLK), .RESET(RESET), .ALE(ALE), .IOM(IOM), .RD(RD), .WR(WR), .AD(AD), .A(A),
        .data_out(dout[1]), .data_oe(oe[1]), .READY(rdy[1]), .mem_addr(maddr[1]), .mem_wdata(wdata[1]),
        .mem_we(we[1]), .mem_re(re[1]), .mem_rdata(rdata[1]), .selected(sel[1]));

    bus_cycle_controller #(.IS_IO(1'b0), .BASE_ADDR(20'h00000), .ADDR_MASK(20'hF0000), .WAIT_STATES(3), .MEM_AW(16)) u_ws3 (
        .CLK(CLK), .RESET(RESET), .ALE(ALE), .IOM(IOM), .RD(RD), .WR(WR), .AD(AD), .A(A),
        .data_out(dout[2]), .data_oe(oe[2]), .READY(rdy[2]), .mem_addr(maddr[2]), .mem_wdata(wdata[2]),
        .mem_we(we[2]), .mem_re(re[2]), .mem_rdata(rdata[2]), .selected(sel[2]));

    bus_cycle_controller #(.IS_IO(1'b1), .BASE_ADDR(20'h00080), .ADDR_MASK(20'hFFFF0), .WAIT_STATES(0), .MEM_AW(16)) u_io (
        .CLK(CLK), .RESET(RESET), .ALE(ALE), .IOM(IOM), .RD(RD), .WR(WR), .AD(AD), .A(A),
        .data_out(dout[3]), .data_oe(oe[3]), .READY(rdy[3]), .mem_addr(maddr[3]), .mem_wdata(wdata[3]),
        .mem_we(we[3]), .mem_re(re[3]), .mem_rdata(rdata[3]), .selected(sel[3]));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous RAM per instance: data appears the cycle after mem_re
    always @(posedge CLK) begin
        for (int k = 0; k < 4; k++) begin
            if (we[k]) ram[k][maddr[k][7:0]] <= wdata[k];
            if (re[k]) rdata[k] <= ram[k][maddr[k][7:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        for (int k = 0; k < 4; k++) begin
            if (we[k])   n_we[k]  <= n_we[k] + 1;
            if (re[k])   n_re[k]  <= n_re[k] + 1;
            if (!rdy[k]) n_rdy[k] <= n_rdy[k] + 1;
            if (oe[k])   n_oe[k]  <= n_oe[k] + 1;
            if (sel[k])  n_sel[k] <= n_sel[k] + 1;
            if (oe[k])   check("oe_guard", 32'(!RD && sel[k]), 32'd1);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic snap();
        for (int k = 0; k < 4; k++) begin
            b_we[k]  = n_we[k];
            b_re[k]  = n_re[k];
            b_rdy[k] = n_rdy[k];
            b_oe[k]  = n_oe[k];
            b_sel[k] = n_sel[k];
        end
    endtask

    // ALE cycle, then two clocks so hitting instances sit in ARMED
    task automatic start(input logic [19:0] addr, input logic iom);
        ALE = 1'b1;
        A   = addr[19:8];
        AD  = addr[7:0];
        IOM = iom;
        tick();
        ALE = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        RESET = 1'b1; ALE = 1'b0; IOM = 1'b1; RD = 1'b1; WR = 1'b1; AD = 8'h00; A = 12'h000;
        #2;
        check("rst_ready", 32'(rdy), 32'hF);
        check("rst_oe",    32'(oe),  32'h0);
        check("rst_we",    32'(we),  32'h0);
        check("rst_re",    32'(re),  32'h0);
        check("rst_sel",   32'(sel), 32'h0);
        check("rst_dout",  32'(dout[0]),  32'h0);
        check("rst_maddr", 32'(maddr[2]), 32'h0);
        check("rst_wdata", 32'(wdata[1]), 32'h0);
        tick(); tick();
        RESET = 1'b0;
        tick();

        // Memory write 0x01234 <- 0xA5
        snap();
        start(20'h01234, 1'b1);
        check("wr_sel", 32'(sel), 32'h7);
        WR = 1'b0; AD = 8'hA5;
        tick(); tick();
        check("wr_we_ws0",    32'(we[0]),    32'd1);
        check("wr_addr_ws0",  32'(maddr[0]), 32'h1234);
        check("wr_wdata_ws0", 32'(wdata[0]), 32'hA5);
        check("wr_ready_ws2", 32'(rdy[1]),   32'd0);
        repeat (6) tick();
        WR = 1'b1;
        tick();
        check("wr_sel_end", 32'(sel), 32'h0);
        check("wr_nwe_ws0",  n_we[0] - b_we[0],   32'd1);
        check("wr_nwe_ws2",  n_we[1] - b_we[1],   32'd1);
        check("wr_nwe_ws3",  n_we[2] - b_we[2],   32'd1);
        check("wr_nwe_io",   n_we[3] - b_we[3],   32'd0);
        check("wr_nrdy_ws0", n_rdy[0] - b_rdy[0], 32'd0);
        check("wr_nrdy_ws2", n_rdy[1] - b_rdy[1], 32'd2);
        check("wr_nrdy_ws3", n_rdy[2] - b_rdy[2], 32'd3);

        // Read back 0x01234
        snap();
        start(20'h01234, 1'b1);
        RD = 1'b0;
        tick(); tick(); tick();
        check("rd_re_ws2",    32'(re[1]),  32'd1);
        check("rd_ready_ws2", 32'(rdy[1]), 32'd0);
        tick();
        check("rd_rcap_ready_ws2", 32'(rdy[1]), 32'd1);
        tick();
        check("rd_oe_ws2",   32'(oe[1]),   32'd1);
        check("rd_dout_ws2", 32'(dout[1]), 32'hA5);
        tick(); tick();
        RD = 1'b1;
        #1;
        check("rd_oe_release", 32'(oe[1]), 32'd0);
        tick();
        check("rd_oe_end",  32'(oe),  32'h0);
        check("rd_sel_end", 32'(sel), 32'h0);
        check("rd_nrdy_ws0", n_rdy[0] - b_rdy[0], 32'd1);
        check("rd_nrdy_ws2", n_rdy[1] - b_rdy[1], 32'd3);
        check("rd_nrdy_ws3", n_rdy[2] - b_rdy[2], 32'd4);
        check("rd_nre_ws2",  n_re[1] - b_re[1],   32'd1);
        check("rd_dout_ws0", 32'(dout[0]), 32'hA5);
        check("rd_dout_ws3", 32'(dout[2]), 32'hA5);

        // Decode misses: wrong window, then IO cycle on memory instances
        snap();
        start(20'h21234, 1'b1);
        WR = 1'b0; AD = 8'h5A;
        repeat (5) tick();
        WR = 1'b1;
        tick();
        start(20'h01234, 1'b0);
        RD = 1'b0;
        repeat (6) tick();
        RD = 1'b1;
        tick();
        check("miss_sel_ws0",  n_sel[0] - b_sel[0], 32'd0);
        check("miss_we_ws0",   n_we[0] - b_we[0],   32'd0);
        check("miss_re_ws0",   n_re[0] - b_re[0],   32'd0);
        check("miss_oe_ws0",   n_oe[0] - b_oe[0],   32'd0);
        check("miss_rdy_ws0",  n_rdy[0] - b_rdy[0], 32'd0);
        check("miss_sel_ws3",  n_sel[2] - b_sel[2], 32'd0);
        check("miss_sel_io",   n_sel[3] - b_sel[3], 32'd0);

        // IO instance: IO write hits, memory write to same address ignored
        snap();
        start(20'h0008C, 1'b0);
        WR = 1'b0; AD = 8'h3C;
        repeat (3) tick();
        WR = 1'b1;
        tick();
        check("io_nwe",       n_we[3] - b_we[3], 32'd1);
        check("io_addr",      32'(maddr[3]), 32'h008C);
        check("io_wdata",     32'(wdata[3]), 32'h3C);
        check("io_nwe_mem",   n_we[0] - b_we[0], 32'd0);
        snap();
        start(20'h0008C, 1'b1);
        WR = 1'b0; AD = 8'hC3;
        repeat (3) tick();
        WR = 1'b1;
        tick();
        check("io_memcyc_nwe", n_we[3] - b_we[3],   32'd0);
        check("io_memcyc_sel", n_sel[3] - b_sel[3], 32'd0);
        check("io_memcyc_wd",  32'(wdata[3]), 32'h3C);

        // Asynchronous reset in the middle of a WS3 read
        snap();
        start(20'h01234, 1'b1);
        RD = 1'b0;
        tick(); tick();
        #2;
        RESET = 1'b1;
        #1;
        check("arst_ready", 32'(rdy[2]),  32'd1);
        check("arst_oe",    32'(oe[2]),   32'd0);
        check("arst_sel",   32'(sel[2]),  32'd0);
        check("arst_re",    32'(re[2]),   32'd0);
        check("arst_dout",  32'(dout[2]), 32'h0);
        tick();
        RESET = 1'b0; RD = 1'b1;
        tick();
        check("arst_nre", n_re[2] - b_re[2], 32'd0);
        snap();
        start(20'h01234, 1'b1);
        RD = 1'b0;
        repeat (7) tick();
        check("arst_rd_oe",   32'(oe[2]),   32'd1);
        check("arst_rd_dout", 32'(dout[2]), 32'hA5);
        RD = 1'b1;
        tick();
        check("arst_rd_nre",  n_re[2] - b_re[2],   32'd1);
        check("arst_rd_nrdy", n_rdy[2] - b_rdy[2], 32'd4);

        // RD withdrawn after one wait cycle on WS3
        snap();
        start(20'h01234, 1'b1);
        RD = 1'b0;
        tick(); tick();
        RD = 1'b1;
        tick();
        check("abort_ready", 32'(rdy[2]), 32'd1);
        check("abort_sel",   32'(sel[2]), 32'd0);
        tick();
        check("abort_nre_ws3",  n_re[2] - b_re[2],   32'd0);
        check("abort_noe_ws3",  n_oe[2] - b_oe[2],   32'd0);
        check("abort_nrdy_ws3", n_rdy[2] - b_rdy[2], 32'd2);
        check("abort_nre_ws2",  n_re[1] - b_re[1],   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bus_cycle_controller.md
Name: bus_cycle_controller

Overview:
Peripheral-side bus-cycle sequencer for the 8088 pin bundle. It latches the multiplexed address on ALE and decodes it against a parameterised memory or IO window. For selected cycles it sequences a synchronous RAM read or write, inserts programmable wait states via READY, and controls the tristate enable of the Data bus. One instance serves one memory or IO device; several instances share the bus, with at most one selected per cycle.

Parameters:
IS_IO, 0, 0 = respond to memory cycles (IOM=1); 1 = respond to IO cycles (IOM=0)
BASE_ADDR, 20'h00000, window base address; compared only on mask bits
ADDR_MASK, 20'hF0000, 1 = address bit participates in decode
WAIT_STATES, 0, READY-low cycles inserted per selected access (0..15)
MEM_AW, 16, width of mem_addr (low bits of latched address)

Ports:
CLK  input  1  bus clock
RESET  input  1  asynchronous, active-high reset
ALE  input  1  address latch enable
IOM  input  1  1 = memory cycle, 0 = IO cycle
RD  input  1  active-low read strobe
WR  input  1  active-low write strobe
AD  input  8  multiplexed address/data low byte (sampled)
A  input  12  address bits 19:8
data_out  output  8  read data toward the Data bus
data_oe  output  1  drive enable for the Data bus tristate
READY  output  1  0 = insert wait state
mem_addr  output  MEM_AW  RAM address
mem_wdata  output  8  RAM write data
mem_we  output  1  RAM write strobe, one-cycle pulse
mem_re  output  1  RAM read strobe, one-cycle pulse; mem_rdata is valid the following cycle
mem_rdata  input  8  RAM read data
selected  output  1  cycle currently claimed by this instance

Behaviour:
- Reset values, applied immediately on RESET=1: state IDLE, READY=1, data_oe=0, mem_we=0, mem_re=0, selected=0, data_out=0, mem_addr=0, mem_wdata=0, wait counter=0.
- Address latch: on every clock with ALE=1, addr_q <= {A, AD} and iom_q <= IOM. Decode hit = ((addr_q ^ BASE_ADDR) & ADDR_MASK) == 0 and iom_q == !IS_IO. mem_addr = addr_q[MEM_AW-1:0].
- FSM states:
  - IDLE: on the first clock with ALE=0 after ALE=1, go to DECODE.
  - DECODE: if no hit, return to IDLE; selected stays 0 and no other output changes. If hit, selected=1 and go to ARMED.
  - ARMED: wait for RD=0 or WR=0. If RD=0, go to RWAIT. If WR=0, go to WWAIT. If both are 0 on the same clock, treat as protocol error: go to ENDC with no RAM access. If ALE=1 while ARMED, abandon the cycle and go to IDLE (new address latched).
  - RWAIT: READY=0 while counter < WAIT_STATES. When counter == WAIT_STATES, pulse mem_re and go to RCAP.
  - RCAP: data_out <= mem_rdata, data_oe=1, READY=1, go to ENDC.
  - WWAIT: READY=0 while counter < WAIT_STATES. When counter == WAIT_STATES, mem_wdata <= AD, pulse mem_we, READY=1, go to ENDC.
  - ENDC: hold data_oe on a read until RD=1. When RD=1 and WR=1, data_oe=0, selected=0, go to IDLE.
- Wait counter: 4-bit; cleared on entry to RWAIT/WWAIT; saturates; no wrap.
- READY: 0 only during counted wait cycles. For reads it is also 0 in the RAM-latency cycle (the mem_re cycle). Total read READY-low cycles = WAIT_STATES + 1; write READY-low cycles = WAIT_STATES. Unselected instances hold READY=1.
- Strobe deassertion mid-cycle: if RD or WR returns high before the access completes, abort to IDLE with no mem_we, data_oe=0, READY=1.
- Assertion: data_oe is never 1 unless RD=0 and selected=1.
- RESET during any state: asynchronous return to the reset values above; a pending mem_we is dropped.

Test Plan:
- Memory write, BASE 0x00000, mask 0xF0000, WAIT_STATES=0: ALE with addr 0x01234, IOM=1, WR low, AD=0xA5 -> mem_we one cycle, mem_addr=0x1234, mem_wdata=0xA5, READY never 0.
- Read back the same location with WAIT_STATES=2 -> READY low 3 cycles, data_out=0xA5, data_oe high until RD rises, then 0 next cycle.
- Decode miss: addr 0x21234 or IOM=0 on a memory instance -> selected=0, no mem_re/mem_we, data_oe=0, READY=1 throughout.
- IO instance (IS_IO=1, BASE 0x00080, mask 0xFFFF0): IO write to 0x0008C -> mem_we with mem_addr=0x008C; memory write to 0x0008C -> ignored.
- RESET asserted during RWAIT with WAIT_STATES=3 -> READY=1, data_oe=0, no mem_re, state IDLE; the next valid read completes normally.
- RD raised after 1 wait cycle with WAIT_STATES=3 -> abort, no mem_re, READY=1, data_oe never asserted.
